// File: rtl/seq_pattern_tx_if.sv
// ============================================================================
// Module   : seq_pattern_tx_if
// Purpose  : Handshake and serial-output bundle for seq_pattern_tx.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seq_pattern_tx_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [W-1:0]     pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             gap_en;
  logic             abort;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] reps_left;

  modport master (
    output start, pattern, repeat_cnt, gap_en, abort,
    input  out_bit, out_valid, busy, done, reps_left
  );

  modport slave (
    input  start, pattern, repeat_cnt, gap_en, abort,
    output out_bit, out_valid, busy, done, reps_left
  );
endinterface

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// ============================================================================
// Module   : seq_pattern_tx
// Purpose  : MSB-first serial pattern transmitter with repeat count, optional
//            gap cycle and abort. Define SEQ_TX_PARITY_EN for a parity cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_pattern_tx #(
  parameter int   W       = 4,
  parameter int   CNT_W   = 8,
  parameter logic GAP_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  seq_pattern_tx_if.slave   bus
);

  localparam int             IW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0]  IDX_TOP = IW'(W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    FIN   = 3'd3,
    PAR   = 3'd4
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_pat;
  logic             r_gap_en;
  logic [IW-1:0]    r_idx;
  logic [CNT_W-1:0] r_reps;
  logic             r_out_bit;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;

  logic [IW-1:0]    w_idx_dn;
  assign w_idx_dn = r_idx - IW'(1);

  // Outputs always show what the current state is emitting this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pat       <= '0;
      r_gap_en    <= 1'b0;
      r_idx       <= '0;
      r_reps      <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (r_state != IDLE && bus.abort) begin
      r_state     <= IDLE;
      r_reps      <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.repeat_cnt != '0) begin
              r_pat       <= bus.pattern;
              r_gap_en    <= bus.gap_en;
              r_reps      <= bus.repeat_cnt - CNT_W'(1);
              r_idx       <= IDX_TOP;
              r_out_bit   <= bus.pattern[W-1];
              r_out_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= SHIFT;
            end else begin
              r_reps  <= '0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end

`ifdef SEQ_TX_PARITY_EN
        SHIFT, PAR: begin
`else
        SHIFT: begin
`endif
          if (r_state == SHIFT && r_idx != '0) begin
            r_idx       <= w_idx_dn;
            r_out_bit   <= r_pat[w_idx_dn];
            r_out_valid <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
          end else if (r_state == SHIFT) begin
            r_out_bit   <= ^r_pat;
            r_out_valid <= 1'b1;
            r_state     <= PAR;
`endif
          end else if (r_reps != '0 && r_gap_en) begin
            r_out_bit   <= GAP_BIT;
            r_out_valid <= 1'b0;
            r_state     <= GAP;
          end else if (r_reps != '0) begin
            r_idx       <= IDX_TOP;
            r_reps      <= r_reps - CNT_W'(1);
            r_out_bit   <= r_pat[W-1];
            r_out_valid <= 1'b1;
          end else begin
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= FIN;
          end
        end

        GAP: begin
          r_idx       <= IDX_TOP;
          r_reps      <= r_reps - CNT_W'(1);
          r_out_bit   <= r_pat[W-1];
          r_out_valid <= 1'b1;
          r_state     <= SHIFT;
        end

        FIN: begin
          r_state <= IDLE;
        end

        default: begin
          r_state     <= IDLE;
          r_out_bit   <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_bit   = r_out_bit;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.reps_left = r_reps;

endmodule

`default_nettype wire

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the source side of the bit-serial link that feeds our sequence detectors, e.g. the 1010 detector.
- Loads a W-bit pattern and a repeat count on a start handshake.
- Shifts the pattern out MSB-first, one bit per clock, repeated N times, with an optional idle gap between repeats.
- Signals busy, per-bit valid and a one-cycle done pulse.

Parameters:
- W, 4, pattern width in bits (>=2).
- CNT_W, 8, width of the repeat count.
- GAP_BIT, 1'b0, value driven on out_bit during gap cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  request; sampled only while busy=0.
- pattern  in  W  pattern word; bit W-1 is sent first.
- repeat_cnt  in  CNT_W  number of pattern repetitions.
- gap_en  in  1  1 = insert one gap cycle between repetitions.
- abort  in  1  synchronous abort of the current transfer.
- out_bit  out  1  serial data.
- out_valid  out  1  out_bit carries a pattern bit this cycle.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on normal completion.
- reps_left  out  CNT_W  repetitions not yet started.

Behaviour:
- All outputs are registered. With rst=0, immediately: state IDLE, out_bit=0, out_valid=0, busy=0, done=0, reps_left=0.
- States are IDLE, SHIFT, GAP, FIN.
- IDLE:
  - On start=1 with repeat_cnt!=0, latch pattern, repeat_cnt and gap_en in the same edge.
  - Set busy=1, reps_left=repeat_cnt-1, bit index=W-1, and go to SHIFT.
  - The first bit is therefore valid in the cycle after the start edge (latency 1).
  - On start=1 with repeat_cnt==0: no bits are sent; go to FIN, so done pulses 1 cycle after start and busy is never asserted.
- SHIFT:
  - Each cycle: out_valid=1, out_bit=latched_pattern[index]; index decrements.
  - At index 0:
    - If reps_left!=0 and gap_en=1, go to GAP.
    - If reps_left!=0 and gap_en=0, reload index=W-1, decrement reps_left and stay in SHIFT. The stream is back-to-back with no bubble.
    - If reps_left==0, go to FIN.
- GAP: exactly one cycle with out_valid=0 and out_bit=GAP_BIT. Then reload index=W-1, decrement reps_left and return to SHIFT.
- FIN: done=1 for exactly one cycle, busy=0, out_valid=0, then go to IDLE. busy deasserts in the same cycle that done asserts.
- start while busy=1 is ignored, never queued. start asserted in the FIN cycle is also ignored. Changes to pattern, repeat_cnt or gap_en mid-transfer have no effect.
- abort=1 in any non-IDLE state:
  - Next edge goes to IDLE with out_valid=0, busy=0, reps_left=0.
  - No done pulse.
  - abort has priority over all other transitions. abort in IDLE has no effect.
  - abort and start together in IDLE: start wins.
- Total valid bits = W*repeat_cnt. Total busy cycles = W*repeat_cnt + (gap_en ? repeat_cnt-1 : 0).
- Maximum repeat_cnt = 2^CNT_W-1. No wrap: reps_left saturates at 0.
- Asynchronous reset mid-transfer clears everything as at reset. No done pulse is produced.

Optional Feature:
- Macro SEQ_TX_PARITY_EN.
- When defined: after the last bit of each repetition, one extra cycle with out_valid=1 carries the even parity (XOR of the W pattern bits). This cycle precedes any GAP cycle. Valid bits = (W+1)*repeat_cnt.
- When undefined: no parity cycle; behaviour exactly as above.

Test Plan:
- Reset, then pattern=4'b1010, repeat_cnt=1, gap_en=0, start pulse -> out_bit 1,0,1,0 on cycles 1-4 after start with out_valid=1; done=1 on cycle 5; busy high cycles 1-4.
- pattern=1010, repeat_cnt=3, gap_en=0 -> 12 contiguous valid bits 101010101010; reps_left 2,1,0; a connected 1010 detector fires 5 times (overlapping).
- pattern=1010, repeat_cnt=2, gap_en=1 -> 1010,G,1010 with out_valid=0 and out_bit=0 on cycle 5; done on cycle 10.
- repeat_cnt=0 with start -> done on cycle 1, out_valid and busy never high; start asserted during a busy transfer -> ignored, bit count unchanged.
- abort on cycle 3 of a repeat_cnt=2 transfer -> cycle 4 IDLE, out_valid=0, busy=0, no done pulse; a new start is accepted immediately after.
- rst driven low mid-SHIFT, between clock edges -> all outputs 0 asynchronously; with SEQ_TX_PARITY_EN, pattern 1011 repeat 1 -> bits 1,0,1,1,1 and done on cycle 6.
